// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full adder, LSB first, one bit per clock.
// The A shift register doubles as the result register; sum bits enter at its MSB.
//
// state | meaning
// IDLE  | ready for operands (in_ready=1)
// RUN   | N serial adder steps, one per edge
// DONE  | result presented (out_valid=1), held until out_ready
module serial_add_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         ovf
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          c_out_q, c_out_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fa_s, fa_c;

    assign fa_s = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        c_out_d   = c_out_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d[N-1] = fa_s;
                for (int i = 0; i < N - 1; i++) begin
                    a_d[i] = a_q[i+1];
                end
                b_d     = b_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // carry_q is the carry into the MSB on this last step
                    sum_d   = a_d;
                    c_out_d = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at N = 1, 8 and 32 running side by side.
module tb_serial_add_ctrl;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        longint      t;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_w
        localparam int W = (gi == 0) ? 1 : ((gi == 1) ? 8 : 32);

        logic         rst_n, in_valid, in_ready, sub, out_valid, out_ready, c_out, ovf;
        logic [W-1:0] a, b, sum;
        exp_t         sb[$];
        int           hold_cnt = 0;
        bit           hold_req = 1'b0;
        bit           fin = 1'b0;

        serial_add_ctrl #(.N(W)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .sub       (sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .c_out     (c_out),
            .ovf       (ovf)
        );

        // Reference: plain integer arithmetic on unsigned and signed views.
        function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
            exp_t   e;
            longint ux, uy, sx, sy, sr, lim, msk;
            ux  = longint'(x);
            uy  = longint'(y);
            sx  = longint'($signed(x));
            sy  = longint'($signed(y));
            lim = longint'(1) << (W - 1);
            msk = (longint'(1) << W) - 1;
            if (s) begin
                e.s = 32'((ux - uy) & msk);
                e.c = (ux >= uy);
                sr  = sx - sy;
            end else begin
                e.s = 32'((ux + uy) & msk);
                e.c = ((ux + uy) >> W) != 0;
                sr  = sx + sy;
            end
            e.v = (sr < -lim) || (sr >= lim);
            e.t = 0;
            return e;
        endfunction

        task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
            exp_t e;
            int   k;
            a = x; b = y; sub = s; in_valid = 1'b1;
            k = 0;
            while (!in_ready && k < 400) begin
                @(negedge clk);
                k++;
            end
            if (!in_ready) begin
                chk("accept_timeout", in_ready, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            e   = model(x, y, s);
            e.t = $time;
            sb.push_back(e);
            @(negedge clk);
            k = 0;
            // Operands and in_valid churn until the controller is idle again.
            while (!in_ready && k < 400) begin
                in_valid = 1'($urandom);
                a        = W'($urandom);
                b        = W'($urandom);
                sub      = 1'($urandom);
                @(negedge clk);
                k++;
            end
            in_valid = 1'b0;
            if (!in_ready) chk("return_timeout", in_ready, 1);
        endtask

        task automatic drain();
            int k;
            k = 0;
            while ((sb.size() != 0 || out_valid) && k < 600) begin
                @(negedge clk);
                k++;
            end
            chk("drain_timeout", sb.size(), 0);
        endtask

        task automatic abort_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
            chk("abort_ready", in_ready, 1);
            a = x; b = y; sub = s; in_valid = 1'b1;
            @(posedge clk);
            #3;
            rst_n = 1'b0;
            #1;
            chk("abort_in_ready", in_ready, 1);
            chk("abort_out_valid", out_valid, 0);
            chk("abort_sum", sum, 0);
            chk("abort_c_out", c_out, 0);
            chk("abort_ovf", ovf, 0);
            in_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            chk("post_rst_ready", in_ready, 1);
        endtask

        initial begin : drv
            rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
            #12;
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_sum", sum, 0);
            chk("rst_c_out", c_out, 0);
            chk("rst_ovf", ovf, 0);
            @(negedge clk);
            rst_n = 1'b1;
            issue(W'(32'h3C), W'(32'h45), 1'b0);
            issue(W'(32'h05), W'(32'h07), 1'b1);
            issue(W'(32'h80), W'(32'h01), 1'b1);
            issue('1, '1, 1'b0);
            issue('0, '1, 1'b1);
            drain();
            hold_req = 1'b1;
            issue(W'(32'hFF), W'(32'h01), 1'b0);
            drain();
            abort_op(W'(32'hAA), W'(32'h55), 1'b0);
            issue(W'(32'h3C), W'(32'h45), 1'b0);
            for (int i = 0; i < 1000; i++) begin
                issue(W'($urandom), W'($urandom), 1'($urandom));
            end
            drain();
            fin = 1'b1;
        end

        initial begin : mon
            exp_t         e;
            logic [W-1:0] h_s;
            logic         h_c, h_v, prev_ov, hs;
            prev_ov = 1'b0; hs = 1'b0; out_ready = 1'b0;
            h_s = '0; h_c = 1'b0; h_v = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    prev_ov   = 1'b0;
                    hs        = 1'b0;
                    out_ready = 1'b0;
                end else begin
                    if (hs) begin
                        chk("ready_after_hs", in_ready, 1);
                        chk("sum_kept_idle", sum, h_s);
                    end
                    if (out_valid && in_ready) chk("ready_in_done", in_ready, 0);
                    if (out_valid && !prev_ov) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_out_valid", out_valid, 0);
                        end else begin
                            e = sb.pop_front();
                            chk("sum", sum, e.s);
                            chk("c_out", c_out, e.c);
                            chk("ovf", ovf, e.v);
                            chk("latency", $time - e.t, W * 10 + 5);
                        end
                        h_s = sum; h_c = c_out; h_v = ovf;
                        if (hold_req) begin
                            hold_cnt = 5;
                            hold_req = 1'b0;
                        end
                    end else if (out_valid) begin
                        chk("hold_sum", sum, h_s);
                        chk("hold_c_out", c_out, h_c);
                        chk("hold_ovf", ovf, h_v);
                    end
                    prev_ov = out_valid;
                    if (hold_cnt > 0) begin
                        out_ready = 1'b0;
                        hold_cnt--;
                    end else begin
                        out_ready = ($urandom_range(0, 2) != 0);
                    end
                    hs = out_valid && out_ready;
                end
            end
        end
    end

    initial begin : top
        int k;
        k = 0;
        while (!(g_w[0].fin && g_w[1].fin && g_w[2].fin) && k < 95000) begin
            @(posedge clk);
            k++;
        end
        if (k >= 95000) chk("global_timeout", {g_w[0].fin, g_w[1].fin, g_w[2].fin}, 3'b111);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand width in bits; legal range 1..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  controller can accept operands.
REQ-006 SHALL have port a  input  N  operand A, unsigned or two's complement.
REQ-007 SHALL have port b  input  N  operand B, unsigned or two's complement.
REQ-008 SHALL have port sub  input  1  0 = A+B, 1 = A-B.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port sum  output  N  result bits.
REQ-012 SHALL have port c_out  output  1  carry out of MSB; for subtract, 1 = no borrow.
REQ-013 SHALL have port ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 SHALL compute the result bit-serially with one single-bit full adder (s = x^y^c_in; c_out = majority), one bit per clock, LSB first.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; only these three states reachable.
REQ-016 SHALL drive in_ready = 1 only in IDLE, out_valid = 1 only in DONE.
REQ-017 IDLE: on edge with in_valid & in_ready, SHALL latch a into shift reg A, b (inverted when sub=1) into shift reg B, load carry reg with sub, clear bit counter, go to RUN.
REQ-018 RUN: each edge SHALL feed A[0], B[0], carry into the full adder, shift A and B right, shift adder sum bit into MSB of result reg, update carry reg, increment counter.
REQ-019 RUN SHALL last exactly N edges; on the edge processing bit N-1 it SHALL capture carry into MSB (for ovf) and carry out, and go to DONE.
REQ-020 Latency: accept at edge T SHALL give out_valid = 1 after edge T+N; back-to-back throughput one operation per N+2 cycles.
REQ-021 DONE: sum, c_out, ovf SHALL be held stable while out_valid=1 and out_ready=0.
REQ-022 DONE: on edge with out_ready=1, SHALL go to IDLE; sum/c_out/ovf keep last values until the next result.
REQ-023 in_valid, a, b, sub SHALL be ignored outside IDLE; operand changes during RUN SHALL NOT affect the result.
REQ-024 in_valid asserted in the same cycle DONE is left SHALL NOT be accepted (in_ready=0 in DONE); accept occurs no earlier than the following cycle in IDLE.
REQ-025 Arithmetic SHALL be modulo 2^N; sum equals (A + B) mod 2^N or (A - B) mod 2^N.
REQ-026 N=1 SHALL work: RUN lasts one edge; ovf = c_in XOR c_out of that single bit.
REQ-027 Bit counter SHALL be clog2(N)+1 bits wide and SHALL NOT wrap within one operation.

Reset
REQ-028 rst_n low SHALL immediately (without clock) force IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0, shift, carry, counter registers=0.
REQ-029 Reset asserted in RUN or DONE SHALL abort the operation; no out_valid for the aborted request after release.
REQ-030 After rst_n deasserts, first accept SHALL be possible on the first rising edge.

Verification
REQ-031 N=8, add a=0x3C b=0x45 sub=0 -> out_valid exactly 8 edges after accept, sum=0x81, c_out=0, ovf=1.
REQ-032 N=8, sub a=0x05 b=0x07 -> sum=0xFE, c_out=0 (borrow), ovf=0; a=0x80 b=0x01 sub=1 -> sum=0x7F, c_out=1, ovf=1.
REQ-033 N=8, add 0xFF+0x01 with out_ready held 0 for 5 cycles -> sum=0x00, c_out=1, ovf=0 held stable; in_ready stays 0 until one cycle after out_ready.
REQ-034 Toggle a/b/sub and in_valid every cycle during RUN -> result unchanged from latched operands.
REQ-035 Assert rst_n=0 mid-RUN between clock edges -> outputs clear asynchronously, no out_valid after release, next request correct.
REQ-036 Randomised 1000 ops for N=1, 8, 32 with random out_ready stalls vs. reference model -> all sum/c_out/ovf match, latency always N.
